fake_n64_bus_sequencer: RTL and testbench

Sequences the single-wire Joybus line for the fake N64 controller. It accepts decoded console commands from the receive path and qualifies them. It then waits a turnaround guard, hands the line to the response transmitter and returns the line to receive once the response and a recovery guard are complete. It owns cur_operation and the cmd fed to the transmitter.

---
 rtl/fake_n64_pkg.sv | 29 ++
 rtl/fake_n64_guard_counter.sv | 39 +++
 rtl/fake_n64_bus_sequencer.sv | 158 +++++++++++++++
 tb/tb_fake_n64_bus_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fake_n64_pkg.sv
// Shared definitions for the fake N64 controller: sequencer state encoding,
// Joybus command bytes and line-ownership values.
package fake_n64_pkg;

    localparam int STATE_SIZE = 4;

    // One-hot state encoding.
    typedef enum logic [STATE_SIZE-1:0] {
        IDLE_RX    = 4'b0001,
        TURNAROUND = 4'b0010,
        TX_ACTIVE  = 4'b0100,
        RECOVER    = 4'b1000
    } seq_state_t;

    localparam logic [7:0] CMD_INFO   = 8'h00;
    localparam logic [7:0] CMD_STATUS = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_WRITE  = 8'h03;
    localparam logic [7:0] CMD_RESET  = 8'hFF;

    localparam logic OP_RX = 1'b0;
    localparam logic OP_TX = 1'b1;

    // Commands this controller answers; everything else is dropped.
    function automatic logic is_supported_cmd(input logic [7:0] c);
        return (c == CMD_INFO) || (c == CMD_STATUS) || (c == CMD_RESET);
    endfunction

endpackage

// File: rtl/fake_n64_guard_counter.sv
// Loadable saturating counter with a terminal-count flag. Shared by the
// turnaround, recovery and watchdog timing of the bus sequencer.
module fake_n64_guard_counter #(
    parameter int CNT_WIDTH = 12
) (
    input  logic                 sample_clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 count_en,
    input  logic [CNT_WIDTH-1:0] last_value,
    output logic                 at_last
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise increment and stick at all-ones.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_last = (count_q == last_value);

endmodule

// File: rtl/fake_n64_bus_sequencer.sv
// Joybus line sequencer: qualifies received commands, waits a turnaround
// guard, hands the line to the transmitter, then waits a recovery guard
// before returning the line to receive. All outputs are registered.
// Optional TX watchdog: define FAKE_N64_TX_WATCHDOG_EN.
module fake_n64_bus_sequencer
    import fake_n64_pkg::*;
#(
    parameter int TURNAROUND_CYCLES = 8,
    parameter int RECOVER_CYCLES    = 4,
    parameter int CNT_WIDTH         = 12,
    parameter int TX_TIMEOUT        = 1024
) (
    input  logic       sample_clk,
    input  logic       reset,
    input  logic       rx_cmd_valid,
    input  logic [7:0] rx_cmd,
    input  logic       rx_error,
    input  logic       tx_done,
    output logic       cur_operation,
    output logic [7:0] cmd,
    output logic       tx_start,
    output logic       cmd_reject,
    output logic       busy,
    output logic       tx_abort
);

    // The counter is cleared on every state change, so a zero-length guard
    // behaves like a one-cycle guard: the flag is already true on entry.
    localparam logic [CNT_WIDTH-1:0] TURN_LAST =
        (TURNAROUND_CYCLES == 0) ? '0 : CNT_WIDTH'(TURNAROUND_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RECOVER_LAST =
        (RECOVER_CYCLES == 0) ? '0 : CNT_WIDTH'(RECOVER_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TX_LAST = CNT_WIDTH'(TX_TIMEOUT);

    seq_state_t           state_q, state_d;
    logic [7:0]           cmd_q, cmd_d;
    logic                 tx_entry_q, tx_entry_d;
    logic                 tx_start_q, tx_start_d;
    logic                 cmd_reject_q, cmd_reject_d;
    logic                 tx_abort_q, tx_abort_d;
    logic                 cur_op_q, cur_op_d;
    logic                 busy_q, busy_d;

    logic                 cnt_clear;
    logic                 cnt_en;
    logic [CNT_WIDTH-1:0] cnt_last;
    logic                 cnt_at_last;

    fake_n64_guard_counter #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_guard_counter (
        .sample_clk (sample_clk),
        .reset      (reset),
        .clear      (cnt_clear),
        .count_en   (cnt_en),
        .last_value (cnt_last),
        .at_last    (cnt_at_last)
    );

    // Next-state, counter control and next values of the registered outputs.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;
        cnt_last     = TURN_LAST;
        cmd_reject_d = 1'b0;
        tx_abort_d   = 1'b0;

        unique case (state_q)
            IDLE_RX: begin
                if (rx_cmd_valid) begin
                    if (!rx_error && is_supported_cmd(rx_cmd)) begin
                        cmd_d     = rx_cmd;
                        state_d   = TURNAROUND;
                        cnt_clear = 1'b1;
                    end else begin
                        cmd_reject_d = 1'b1;
                    end
                end
            end
            TURNAROUND: begin
                cnt_en   = 1'b1;
                cnt_last = TURN_LAST;
                if (cnt_at_last) begin
                    state_d   = TX_ACTIVE;
                    cnt_clear = 1'b1;
                end
            end
            TX_ACTIVE: begin
                cnt_last = TX_LAST;
                if (tx_done) begin
                    state_d   = RECOVER;
                    cnt_clear = 1'b1;
                end
`ifdef FAKE_N64_TX_WATCHDOG_EN
                cnt_en = 1'b1;
                if (!tx_done && cnt_at_last) begin
                    state_d    = IDLE_RX;
                    cnt_clear  = 1'b1;
                    tx_abort_d = 1'b1;
                end
`endif
            end
            RECOVER: begin
                cnt_en   = 1'b1;
                cnt_last = RECOVER_LAST;
                if (cnt_at_last) begin
                    state_d   = IDLE_RX;
                    cnt_clear = 1'b1;
                end
            end
            default: begin
                state_d = IDLE_RX;
            end
        endcase

        // Outputs follow the current state one clock later; an abort drops
        // line ownership in the same clock as the abort pulse.
        tx_entry_d = (state_q == TURNAROUND) && (state_d == TX_ACTIVE);
        tx_start_d = tx_entry_q;
        cur_op_d   = ((state_q == TX_ACTIVE) || (state_q == RECOVER)) && !tx_abort_d
                     ? OP_TX : OP_RX;
        busy_d     = (state_q != IDLE_RX) && !tx_abort_d;
    end

    // State and output registers.
    always_ff @(posedge sample_clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE_RX;
            cmd_q        <= 8'h00;
            tx_entry_q   <= 1'b0;
            tx_start_q   <= 1'b0;
            cmd_reject_q <= 1'b0;
            tx_abort_q   <= 1'b0;
            cur_op_q     <= OP_RX;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            tx_entry_q   <= tx_entry_d;
            tx_start_q   <= tx_start_d;
            cmd_reject_q <= cmd_reject_d;
            tx_abort_q   <= tx_abort_d;
            cur_op_q     <= cur_op_d;
            busy_q       <= busy_d;
        end
    end

    assign cur_operation = cur_op_q;
    assign cmd           = cmd_q;
    assign tx_start      = tx_start_q;
    assign cmd_reject    = cmd_reject_q;
    assign busy          = busy_q;
    assign tx_abort      = tx_abort_q;

endmodule

// File: tb/tb_fake_n64_bus_sequencer.sv
// Directed self-checking bench for fake_n64_bus_sequencer (default timing,
// TX_TIMEOUT reduced to 16 for the watchdog build).
module tb_fake_n64_bus_sequencer;

    logic       sample_clk = 1'b0;
    logic       reset;
    logic       rx_cmd_valid;
    logic [7:0] rx_cmd;
    logic       rx_error;
    logic       tx_done;
    logic       cur_operation;
    logic [7:0] cmd;
    logic       tx_start;
    logic       cmd_reject;
    logic       busy;
    logic       tx_abort;

    int checks   = 0;
    int failures = 0;

    fake_n64_bus_sequencer #(
        .TURNAROUND_CYCLES (8),
        .RECOVER_CYCLES    (4),
        .CNT_WIDTH         (12),
        .TX_TIMEOUT        (16)
    ) dut (
        .sample_clk    (sample_clk),
        .reset         (reset),
        .rx_cmd_valid  (rx_cmd_valid),
        .rx_cmd        (rx_cmd),
        .rx_error      (rx_error),
        .tx_done       (tx_done),
        .cur_operation (cur_operation),
        .cmd           (cmd),
        .tx_start      (tx_start),
        .cmd_reject    (cmd_reject),
        .busy          (busy),
        .tx_abort      (tx_abort)
    );

    always #5 sample_clk = ~sample_clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge sample_clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_cmd_valid = 1'b0; rx_cmd = 8'h00; rx_error = 1'b0; tx_done = 1'b0;
        step(); step();
        checks++; if ({cur_operation, busy, tx_start, cmd_reject, tx_abort} !== 5'b0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=00000",
                                 {cur_operation, busy, tx_start, cmd_reject, tx_abort});
        end
        checks++; if (cmd !== 8'h00) begin
            failures++; $display("FAIL reset_cmd got=%h exp=00", cmd);
        end
        reset = 1'b0;
        step(); step();
        checks++; if ({cur_operation, busy} !== 2'b00) begin
            failures++; $display("FAIL post_reset_idle got=%b exp=00", {cur_operation, busy});
        end
    endtask

    // Accept command c; returns on the falling edge after accept+10 (TX owns the line).
    task automatic test_accept(input logic [7:0] c);
        rx_cmd_valid = 1'b1; rx_cmd = c;
        step();
        rx_cmd_valid = 1'b0;
        checks++; if (cmd !== c) begin
            failures++; $display("FAIL accept_cmd got=%h exp=%h", cmd, c);
        end
        checks++; if ({busy, cmd_reject} !== 2'b00) begin
            failures++; $display("FAIL accept_n_flags got=%b exp=00", {busy, cmd_reject});
        end
        step();
        checks++; if ({busy, cur_operation, tx_start} !== 3'b100) begin
            failures++; $display("FAIL accept_n1 busy/curop/start got=%b exp=100",
                                 {busy, cur_operation, tx_start});
        end
        for (int k = 2; k <= 8; k++) begin
            step();
            checks++; if ({cur_operation, tx_start} !== 2'b00) begin
                failures++; $display("FAIL turnaround_n%0d curop/start got=%b exp=00",
                                     k, {cur_operation, tx_start});
            end
        end
        step();
        checks++; if ({cur_operation, tx_start} !== 2'b11) begin
            failures++; $display("FAIL tx_start_n9 curop/start got=%b exp=11",
                                 {cur_operation, tx_start});
        end
        step();
        checks++; if ({cur_operation, tx_start} !== 2'b10) begin
            failures++; $display("FAIL tx_start_n10 curop/start got=%b exp=10",
                                 {cur_operation, tx_start});
        end
    endtask

    // Pulse tx_done while in TX; line must be back to Rx exactly 5 cycles later.
    task automatic test_tx_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            if (k != 0) step();
            checks++; if ({cur_operation, busy} !== 2'b11) begin
                failures++; $display("FAIL recover_m%0d curop/busy got=%b exp=11",
                                     k, {cur_operation, busy});
            end
        end
        step();
        checks++; if ({cur_operation, busy} !== 2'b00) begin
            failures++; $display("FAIL recover_m5 curop/busy got=%b exp=00",
                                 {cur_operation, busy});
        end
    endtask

    task automatic test_reject();
        logic [7:0] bad [2];
        bad[0] = 8'h02; bad[1] = 8'h03;
        for (int i = 0; i < 2; i++) begin
            rx_cmd_valid = 1'b1; rx_cmd = bad[i];
            step();
            rx_cmd_valid = 1'b0;
            checks++; if ({cmd_reject, cmd} !== {1'b1, 8'hFF}) begin
                failures++; $display("FAIL reject_%h reject/cmd got=%b/%h exp=1/ff",
                                     bad[i], cmd_reject, cmd);
            end
            step();
            checks++; if ({cmd_reject, busy, cur_operation, tx_start} !== 4'b0000) begin
                failures++; $display("FAIL reject_%h_after got=%b exp=0000",
                                     bad[i], {cmd_reject, busy, cur_operation, tx_start});
            end
        end
    endtask

    task automatic test_error_and_ignore();
        // Error and valid together: error wins.
        rx_cmd_valid = 1'b1; rx_error = 1'b1; rx_cmd = 8'h00;
        step();
        rx_cmd_valid = 1'b0; rx_error = 1'b0;
        checks++; if ({cmd_reject, cmd} !== {1'b1, 8'hFF}) begin
            failures++; $display("FAIL error_wins reject/cmd got=%b/%h exp=1/ff", cmd_reject, cmd);
        end
        step();
        checks++; if ({busy, cmd_reject} !== 2'b00) begin
            failures++; $display("FAIL error_no_accept busy/reject got=%b exp=00", {busy, cmd_reject});
        end
        // Error alone and tx_done while idle: nothing happens.
        rx_error = 1'b1; tx_done = 1'b1;
        step();
        rx_error = 1'b0; tx_done = 1'b0;
        step();
        checks++; if ({busy, cmd_reject, cur_operation} !== 3'b000) begin
            failures++; $display("FAIL idle_ignores got=%b exp=000", {busy, cmd_reject, cur_operation});
        end
        // Accept 00, then a new command during turnaround is ignored.
        rx_cmd_valid = 1'b1; rx_cmd = 8'h00;
        step();
        rx_cmd_valid = 1'b0;
        step(); step();
        rx_cmd_valid = 1'b1; rx_cmd = 8'h01;
        step();
        rx_cmd_valid = 1'b0;
        checks++; if ({cmd_reject, cmd} !== {1'b0, 8'h00}) begin
            failures++; $display("FAIL turnaround_ignore reject/cmd got=%b/%h exp=0/00", cmd_reject, cmd);
        end
        // Now at accept+3; tx_start still due at accept+9.
        for (int k = 4; k <= 8; k++) step();
        checks++; if (cur_operation !== 1'b0) begin
            failures++; $display("FAIL turnaround_n8 curop got=%b exp=0", cur_operation);
        end
        step();
        checks++; if ({cur_operation, tx_start} !== 2'b11) begin
            failures++; $display("FAIL turnaround_n9 curop/start got=%b exp=11", {cur_operation, tx_start});
        end
        test_tx_done();
    endtask

    task automatic test_reset_mid_tx();
        test_accept(8'h01);
        #2 reset = 1'b1;
        #1;
        checks++; if ({cur_operation, busy, tx_start, cmd} !== {3'b000, 8'h00}) begin
            failures++; $display("FAIL async_reset curop/busy/start/cmd got=%b/%h exp=000/00",
                                 {cur_operation, busy, tx_start}, cmd);
        end
        step();
        reset = 1'b0;
        step(); step();
        checks++; if ({cur_operation, busy} !== 2'b00) begin
            failures++; $display("FAIL after_reset_release got=%b exp=00", {cur_operation, busy});
        end
    endtask

    task automatic test_tx_hold();
        int bad;
        test_accept(8'h01);
        bad = 0;
`ifdef FAKE_N64_TX_WATCHDOG_EN
        // tx_start at accept+9; abort after 16 TX cycles at accept+25.
        for (int k = 11; k <= 24; k++) begin
            step();
            if ({cur_operation, tx_abort} !== 2'b10) bad++;
        end
        checks++; if (bad != 0) begin
            failures++; $display("FAIL watchdog_early bad_cycles=%0d exp=0", bad);
        end
        step();
        checks++; if ({tx_abort, cur_operation, busy} !== 3'b100) begin
            failures++; $display("FAIL watchdog_abort abort/curop/busy got=%b exp=100",
                                 {tx_abort, cur_operation, busy});
        end
        step();
        checks++; if ({tx_abort, cur_operation, busy} !== 3'b000) begin
            failures++; $display("FAIL watchdog_after got=%b exp=000", {tx_abort, cur_operation, busy});
        end
`else
        for (int k = 0; k < 2100; k++) begin
            step();
            if ({cur_operation, busy, tx_abort} !== 3'b110) bad++;
        end
        checks++; if (bad != 0) begin
            failures++; $display("FAIL tx_hold_no_watchdog bad_cycles=%0d exp=0", bad);
        end
        test_tx_done();
`endif
    endtask

    initial begin
        test_reset();
        test_accept(8'h01);
        test_tx_done();
        test_accept(8'hFF);
        test_tx_done();
        test_reject();
        test_error_and_ignore();
        test_reset_mid_tx();
        test_tx_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout reached time=%0t", $time);
        $fatal(1, "simulation time limit");
    end

endmodule
